// File: rtl/cont_stream_framer.sv
// ---------------------------------------------------------------------------
// cont_stream_framer
//
// Write-side source for the continuous-stream dual-clock FIFO. Upstream
// payload words arrive on a valid/ready interface and are held in a small
// buffer. Each frame goes out as an unbroken run of wen-high words: payload
// words carry the enable flag at bit EN_BIT, and every frame closes with
// TAIL_LEN all-zero trailer words and then a wen-low gap. The receiving end
// uses the trailer to reset its pointers and return to idle.
//
// Ports:
//   CLK       in   1     clock (WCLK domain)
//   RST_X     in   1     synchronous active-low reset
//   s_valid   in   1     upstream word valid
//   s_ready   out  1     upstream may transfer (buffer not full)
//   s_data    in   DW-1  payload without the enable flag
//   s_last    in   1     last payload word of a frame
//   wen       out  1     FIFO write enable (registered)
//   dout      out  DW    FIFO data word (registered)
//   busy      out  1     high whenever the framer is not idle
//   underrun  out  1     one-cycle pulse: buffer ran dry mid-frame
//   truncate  out  1     one-cycle pulse: frame cut at MAX_FRAME words
// ---------------------------------------------------------------------------
module cont_stream_framer #(
    parameter int DW        = 27,
    parameter int EN_BIT    = 25,
    parameter int BUF_LOG   = 4,
    parameter int START_THR = 8,
    parameter int TAIL_LEN  = 2,
    parameter int GAP_LEN   = 4,
    parameter int MAX_FRAME = 200
) (
    input  logic          CLK,
    input  logic          RST_X,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-2:0] s_data,
    input  logic          s_last,
    output logic          wen,
    output logic [DW-1:0] dout,
    output logic          busy,
    output logic          underrun,
    output logic          truncate
);

    localparam int DEPTH = 1 << BUF_LOG;
    localparam int WCW   = $clog2(MAX_FRAME + 1);
    localparam int TCW   = $clog2(TAIL_LEN + 1);
    localparam int GCW   = (GAP_LEN > 2) ? $clog2(GAP_LEN) : 1;

    localparam logic [BUF_LOG:0] FULL_CNT  = (BUF_LOG + 1)'(DEPTH);
    localparam logic [BUF_LOG:0] START_CNT = (BUF_LOG + 1)'(START_THR);
    localparam logic [WCW-1:0]   MAX_LAST  = WCW'(MAX_FRAME - 1);
    localparam logic [TCW-1:0]   TAIL_LAST = TCW'(TAIL_LEN - 1);
    // The IDLE decision cycle is itself one of the wen-low gap cycles, so
    // the GAP state only has to cover GAP_LEN-1 of them.
    localparam logic [GCW-1:0]   GAP_LAST  = GCW'((GAP_LEN >= 2) ? GAP_LEN - 2 : 0);

    // Masks used to open a hole at EN_BIT in the payload word.
    localparam logic [DW-1:0] LO_MASK = {DW{1'b1}} >> (DW - EN_BIT);
    localparam logic [DW-1:0] EN_FLAG = DW'(1) << EN_BIT;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_TAIL   = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

    // Buffer entries are {last, data}, which is exactly DW bits wide.
    logic [DW-1:0]    mem [DEPTH];
    logic [BUF_LOG-1:0] wr_ptr;
    logic [BUF_LOG-1:0] rd_ptr;
    logic [BUF_LOG:0] count;
    logic [BUF_LOG:0] lastcnt;

    logic [1:0]     state;
    logic [WCW-1:0] wcnt;
    logic [TCW-1:0] tcnt;
    logic [GCW-1:0] gcnt;
    logic           drop;
    logic           cut;

    logic           push;
    logic           pop;
    logic           empty;
    logic [DW-1:0]  head;
    logic           head_last;
    logic [DW-1:0]  head_ext;
    logic [DW-1:0]  payload;

    // Handshake, pop decision and payload formatting of the buffer head.
    // Pops only happen while streaming or while discarding the remainder
    // of an underrun frame in IDLE.
    always_comb begin
        s_ready   = (count != FULL_CNT);
        push      = s_valid & s_ready;
        empty     = (count == '0);
        pop       = !empty && ((state == ST_STREAM) || (state == ST_IDLE && drop));
        head      = mem[rd_ptr];
        head_last = head[DW-1];
        head_ext  = {1'b0, head[DW-2:0]};
        payload   = (head_ext & LO_MASK) | ((head_ext & ~LO_MASK) << 1) | EN_FLAG;
        busy      = (state != ST_IDLE);
    end

    // Buffer storage; contents need no reset because the pointers define
    // what is valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {s_last, s_data};
        end
    end

    // Buffer pointers, occupancy and the count of buffered frame ends.
    // lastcnt lets a short frame start before START_THR words are present.
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            lastcnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            case ({push & s_last, pop & head_last})
                2'b10:   lastcnt <= lastcnt + 1'b1;
                2'b01:   lastcnt <= lastcnt - 1'b1;
                default: lastcnt <= lastcnt;
            endcase
        end
    end

    // Frame sequencer. Outputs are registered here, so every word and pulse
    // appears one cycle after the decision that produced it. wen stays high
    // from the first payload word through the last trailer word.
    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state    <= ST_IDLE;
            wen      <= 1'b0;
            dout     <= '0;
            underrun <= 1'b0;
            truncate <= 1'b0;
            wcnt     <= '0;
            tcnt     <= '0;
            gcnt     <= '0;
            drop     <= 1'b0;
            cut      <= 1'b0;
        end else begin
            wen      <= 1'b0;
            dout     <= '0;
            underrun <= 1'b0;
            truncate <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (drop) begin
                        // Discard the tail of a frame that already underran.
                        if (pop && head_last) begin
                            drop <= 1'b0;
                        end
                    end else if (count >= START_CNT || lastcnt != '0) begin
                        state <= ST_STREAM;
                        wcnt  <= '0;
                    end
                end
                ST_STREAM: begin
                    wen <= 1'b1;
                    if (!empty) begin
                        dout <= payload;
                        wcnt <= wcnt + 1'b1;
                        if (head_last) begin
                            state <= ST_TAIL;
                            tcnt  <= '0;
                            cut   <= 1'b0;
                        end else if (wcnt == MAX_LAST) begin
                            state <= ST_TAIL;
                            tcnt  <= '0;
                            cut   <= 1'b1;
                        end
                    end else begin
                        // Ran dry: this cycle already carries trailer word 1.
                        dout     <= '0;
                        underrun <= 1'b1;
                        drop     <= 1'b1;
                        cut      <= 1'b0;
                        state    <= ST_TAIL;
                        tcnt     <= TCW'(1);
                    end
                end
                ST_TAIL: begin
                    wen  <= 1'b1;
                    dout <= '0;
                    if (tcnt == '0) begin
                        truncate <= cut;
                    end
                    if (tcnt == TAIL_LAST) begin
                        state <= (GAP_LEN == 1) ? ST_IDLE : ST_GAP;
                        gcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: begin
                    if (gcnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
